// File: rtl/multi_timer_pkg.sv
// Shared register map, CTRL bit positions and mode encoding for the multi-channel timer.
package multi_timer_pkg;

    localparam logic [3:0] OFF_CTRL        = 4'h0;
    localparam logic [3:0] OFF_COUNT       = 4'h4;
    localparam logic [3:0] OFF_EVALUE      = 4'h8;
    localparam logic [7:0] ADDR_INT_STATUS = 8'hF0;
    localparam int         CH_STRIDE       = 16;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IE     = 1;
    localparam int CTRL_PEND   = 2;
    localparam int CTRL_MODE   = 3;
    localparam int CTRL_PS_LSB = 8;
    localparam int CTRL_PS_MSB = 15;

    typedef enum logic {
        MODE_ONESHOT  = 1'b0,
        MODE_PERIODIC = 1'b1
    } mode_e;

endpackage

// File: rtl/multi_timer_if.sv
// Peripheral register bus shared with the UART/GPIO blocks.
interface multi_timer_if;

    logic        wr_en_i;
    logic [31:0] wr_addr_i;
    logic [31:0] wr_data_i;
    logic [31:0] rd_addr_i;
    logic [31:0] rd_data_o;

    modport master (output wr_en_i, wr_addr_i, wr_data_i, rd_addr_i, input rd_data_o);
    modport slave  (input wr_en_i, wr_addr_i, wr_data_i, rd_addr_i, output rd_data_o);

endinterface

// File: rtl/multi_timer_ch.sv
// One timer channel: CTRL/COUNT/EVALUE, optional prescaler, expiry logic.
// Prescaler present only when MULTI_TIMER_PRESCALE_EN is defined.
module multi_timer_ch
    import multi_timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_wr,
    input  logic        evalue_wr,
    input  logic [31:0] wr_data,
    output logic [31:0] ctrl_rd,
    output logic [31:0] count_rd,
    output logic [31:0] evalue_rd,
    output logic        pending,
    output logic        int_en
);

    logic             enable;
    logic             enable_nxt;
    mode_e            mode;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] evalue;
    logic [7:0]       prescale;
    logic             tick;
    logic             expire;

`ifdef MULTI_TIMER_PRESCALE_EN
    logic [7:0] psc;

    assign tick = enable && (psc == prescale);

    always_ff @(posedge clk) begin
        if (rst) begin
            prescale <= '0;
            psc      <= '0;
        end else begin
            if (ctrl_wr)
                prescale <= wr_data[CTRL_PS_MSB:CTRL_PS_LSB];
            if (ctrl_wr || !enable || tick)
                psc <= '0;
            else
                psc <= psc + 8'd1;
        end
    end
`else
    assign prescale = '0;
    assign tick     = enable;
`endif

    // COUNT only increments while below EVALUE, so it can never wrap.
    assign expire = tick && (count >= evalue);

    // Software write of enable overrides the one-shot self-disable.
    always_comb begin
        enable_nxt = enable;
        if (expire && mode == MODE_ONESHOT)
            enable_nxt = 1'b0;
        if (ctrl_wr)
            enable_nxt = wr_data[CTRL_EN];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable  <= 1'b0;
            int_en  <= 1'b0;
            pending <= 1'b0;
            mode    <= MODE_ONESHOT;
            count   <= '0;
            evalue  <= '0;
        end else begin
            enable <= enable_nxt;
            if (ctrl_wr) begin
                int_en <= wr_data[CTRL_IE];
                mode   <= mode_e'(wr_data[CTRL_MODE]);
            end
            if (expire)
                pending <= 1'b1;
            else if (ctrl_wr && !wr_data[CTRL_PEND])
                pending <= 1'b0;
            if (!enable_nxt || expire)
                count <= '0;
            else if (tick)
                count <= count + CNT_W'(1);
            if (evalue_wr)
                evalue <= wr_data[CNT_W-1:0];
        end
    end

    always_comb begin
        ctrl_rd                          = '0;
        ctrl_rd[CTRL_EN]                 = enable;
        ctrl_rd[CTRL_IE]                 = int_en;
        ctrl_rd[CTRL_PEND]               = pending;
        ctrl_rd[CTRL_MODE]               = mode;
        ctrl_rd[CTRL_PS_MSB:CTRL_PS_LSB] = prescale;
        count_rd                         = '0;
        count_rd[CNT_W-1:0]              = count;
        evalue_rd                        = '0;
        evalue_rd[CNT_W-1:0]             = evalue;
    end

endmodule

// File: rtl/multi_timer.sv
// NUM_CH-channel timer: address decode, read mux and interrupt aggregation.
// Optional per-channel prescaler enabled by defining MULTI_TIMER_PRESCALE_EN.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    multi_timer_if.slave      bus,
    output logic [NUM_CH-1:0] timer_int_o,
    output logic              timer_int_flag_o
);

    logic              wr_page;
    logic              rd_page;
    logic [3:0]        wr_ch;
    logic [3:0]        wr_off;
    logic [3:0]        rd_ch;
    logic [3:0]        rd_off;
    logic [NUM_CH-1:0] ctrl_wr;
    logic [NUM_CH-1:0] evalue_wr;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] int_en;
    logic [31:0]       ctrl_rd   [NUM_CH];
    logic [31:0]       count_rd  [NUM_CH];
    logic [31:0]       evalue_rd [NUM_CH];
    logic [31:0]       rd_data_p0;

    assign wr_page = bus.wr_en_i && (bus.wr_addr_i[31:8] == '0);
    assign wr_ch   = bus.wr_addr_i[7:4];
    assign wr_off  = bus.wr_addr_i[3:0];
    assign rd_page = (bus.rd_addr_i[31:8] == '0);
    assign rd_ch   = bus.rd_addr_i[7:4];
    assign rd_off  = bus.rd_addr_i[3:0];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign ctrl_wr[i]   = wr_page && (wr_ch == 4'(i)) && (wr_off == OFF_CTRL);
        assign evalue_wr[i] = wr_page && (wr_ch == 4'(i)) && (wr_off == OFF_EVALUE);

        multi_timer_ch #(.CNT_W(CNT_W)) u_ch (
            .clk       (clk),
            .rst       (rst),
            .ctrl_wr   (ctrl_wr[i]),
            .evalue_wr (evalue_wr[i]),
            .wr_data   (bus.wr_data_i),
            .ctrl_rd   (ctrl_rd[i]),
            .count_rd  (count_rd[i]),
            .evalue_rd (evalue_rd[i]),
            .pending   (pending[i]),
            .int_en    (int_en[i])
        );
    end

    // Channel index 15 never exists (NUM_CH <= 8), so INT_STATUS cannot alias a channel.
    always_comb begin
        rd_data_p0 = '0;
        if (rd_page) begin
            if (bus.rd_addr_i[7:0] == ADDR_INT_STATUS) begin
                rd_data_p0[NUM_CH-1:0] = pending;
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (rd_ch == 4'(i)) begin
                        case (rd_off)
                            OFF_CTRL:   rd_data_p0 = ctrl_rd[i];
                            OFF_COUNT:  rd_data_p0 = count_rd[i];
                            OFF_EVALUE: rd_data_p0 = evalue_rd[i];
                            default:    rd_data_p0 = '0;
                        endcase
                    end
                end
            end
        end
    end

    // Read data register stage.
    always_ff @(posedge clk) begin
        if (rst)
            bus.rd_data_o <= '0;
        else
            bus.rd_data_o <= rd_data_p0;
    end

    assign timer_int_o      = pending & int_en;
    assign timer_int_flag_o = |timer_int_o;

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer with a per-cycle behavioural register model.
module tb_multi_timer;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 32;
`ifdef MULTI_TIMER_PRESCALE_EN
    localparam bit PS = 1'b1;
`else
    localparam bit PS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] timer_int_o;
    logic              timer_int_flag_o;

    multi_timer_if bus();

    multi_timer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus),
        .timer_int_o      (timer_int_o),
        .timer_int_flag_o (timer_int_flag_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Register-level model of every channel
    bit              m_en   [NUM_CH];
    bit              m_ie   [NUM_CH];
    bit              m_pend [NUM_CH];
    bit              m_mode [NUM_CH];
    int unsigned     m_pre  [NUM_CH];
    int unsigned     m_psc  [NUM_CH];
    longint unsigned m_cnt  [NUM_CH];
    longint unsigned m_ev   [NUM_CH];
    logic [31:0]     m_rd;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int ch = int'(a[7:4]);
        int off = int'(a[3:0]);
        logic [31:0] r = '0;
        if (a == 32'hF0) begin
            for (int i = 0; i < NUM_CH; i++) r[i] = m_pend[i];
        end else if (a < 32'h100 && ch < NUM_CH) begin
            if (off == 0)
                r = (m_pre[ch] << 8) | (32'(m_mode[ch]) << 3) | (32'(m_pend[ch]) << 2)
                    | (32'(m_ie[ch]) << 1) | 32'(m_en[ch]);
            else if (off == 4)
                r = m_cnt[ch][31:0];
            else if (off == 8)
                r = m_ev[ch][31:0];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_en[i] = 0; m_ie[i] = 0; m_pend[i] = 0; m_mode[i] = 0;
                m_pre[i] = 0; m_psc[i] = 0; m_cnt[i] = 0; m_ev[i] = 0;
            end
            m_rd = '0;
        end else begin
            m_rd = model_read(bus.rd_addr_i);
            for (int i = 0; i < NUM_CH; i++) begin
                bit wctl, wev, tick, fire;
                logic [31:0] d;
                d    = bus.wr_data_i;
                wctl = bus.wr_en_i && (bus.wr_addr_i == 32'(i * 16));
                wev  = bus.wr_en_i && (bus.wr_addr_i == 32'(i * 16 + 8));
                tick = m_en[i] && (!PS || m_psc[i] == m_pre[i]);
                fire = tick && (m_cnt[i] >= m_ev[i]);
                if (PS) m_psc[i] = (wctl || !m_en[i] || tick) ? 0 : m_psc[i] + 1;
                if (fire) m_cnt[i] = 0;
                else if (tick) m_cnt[i] = m_cnt[i] + 1;
                if (fire) m_pend[i] = 1;
                else if (wctl && !d[2]) m_pend[i] = 0;
                if (fire && !m_mode[i]) m_en[i] = 0;
                if (wctl) begin
                    m_en[i] = d[0]; m_ie[i] = d[1]; m_mode[i] = d[3];
                    if (PS) m_pre[i] = int'(d[15:8]);
                end
                if (!m_en[i]) m_cnt[i] = 0;
                if (wev) m_ev[i] = longint'(d);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            logic [NUM_CH-1:0] ei;
            for (int i = 0; i < NUM_CH; i++) ei[i] = m_pend[i] && m_ie[i];
            check("model_rd_data", bus.rd_data_o, m_rd);
            check("model_timer_int", 32'(timer_int_o), 32'(ei));
            check("model_int_flag", 32'(timer_int_flag_o), 32'(|ei));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.wr_en_i   = 1'b1;
        bus.wr_addr_i = a;
        bus.wr_data_i = d;
        @(negedge clk);
        bus.wr_en_i   = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        bus.rd_addr_i = a;
        @(negedge clk);
        check(name, bus.rd_data_o, exp);
    endtask

    initial begin
        rst           = 1'b1;
        bus.wr_en_i   = 1'b0;
        bus.wr_addr_i = '0;
        bus.wr_data_i = '0;
        bus.rd_addr_i = '0;
        idle(3);
        rst = 1'b0;
        chk_on = 1'b1;

        // Reset state
        for (int c = 0; c < NUM_CH; c++) begin
            rd_chk("rst_ctrl", 32'(c * 16), 32'h0);
            rd_chk("rst_count", 32'(c * 16 + 4), 32'h0);
            rd_chk("rst_evalue", 32'(c * 16 + 8), 32'h0);
        end
        rd_chk("rst_int_status", 32'hF0, 32'h0);
        check("rst_flag", 32'(timer_int_flag_o), 32'h0);

        // Ch0 one-shot, EVALUE=5: interrupt six edges after the CTRL write
        wr(32'h08, 32'd5);
        wr(32'h00, 32'h3);
        idle(5);
        check("ch0_int_early", 32'(timer_int_o), 32'h0);
        idle(1);
        check("ch0_int_fire", 32'(timer_int_o), 32'h1);
        check("ch0_flag_fire", 32'(timer_int_flag_o), 32'h1);
        rd_chk("ch0_ctrl_after", 32'h00, 32'h6);
        rd_chk("ch0_count_after", 32'h04, 32'h0);
        wr(32'h00, 32'h2);
        check("ch0_int_clear", 32'(timer_int_o), 32'h0);
        rd_chk("int_status_clear", 32'hF0, 32'h0);

        // Ch2 periodic, EVALUE=3: expiry every 4 edges
        wr(32'h28, 32'd3);
        wr(32'h20, 32'hB);
        idle(4);
        check("ch2_int_fire", 32'(timer_int_o), 32'h4);
        rd_chk("ch2_int_status", 32'hF0, 32'h4);
        rd_chk("ch2_ctrl", 32'h20, 32'hF);
        wr(32'h20, 32'hB);
        check("ch2_cleared", 32'(timer_int_o), 32'h0);
        idle(1);
        check("ch2_refire", 32'(timer_int_o), 32'h4);
        idle(3);
        wr(32'h20, 32'hB);
        check("ch2_set_wins", 32'(timer_int_o), 32'h4);
        rd_chk("ch2_ctrl_set_wins", 32'h20, 32'hF);
        wr(32'h20, 32'h0);

        // Ch1 one-shot: COUNT write ignored, EVALUE lowered to 0 mid-count
        wr(32'h18, 32'd100);
        wr(32'h10, 32'h3);
        idle(5);
        rd_chk("ch1_count_mid", 32'h14, 32'd5);
        wr(32'h14, 32'h1234);
        wr(32'h18, 32'h0);
        check("ch1_not_yet", 32'(timer_int_o), 32'h0);
        idle(1);
        check("ch1_fire", 32'(timer_int_o), 32'h2);
        rd_chk("ch1_ctrl", 32'h10, 32'h6);
        wr(32'h50, 32'hFFFF_FFFF);
        rd_chk("unmapped_ch", 32'h50, 32'h0);
        rd_chk("unmapped_off", 32'h0C, 32'h0);
        wr(32'h10, 32'h0);

        // Ch3 one-shot expiry coinciding with software enable=1
        wr(32'h38, 32'd2);
        wr(32'h30, 32'h3);
        idle(2);
        wr(32'h30, 32'h3);
        rd_chk("ch3_sw_enable_wins", 32'h30, 32'h7);
        wr(32'h30, 32'h0);

        // Prescaler: prescale=3, EVALUE=2
        wr(32'h00, 32'h0);
        wr(32'h08, 32'd2);
        wr(32'h00, 32'h0303);
        if (PS) begin
            idle(11);
            check("ps_early", 32'(timer_int_o), 32'h0);
            idle(1);
            check("ps_fire", 32'(timer_int_o), 32'h1);
            rd_chk("ps_ctrl", 32'h00, 32'h0306);
        end else begin
            idle(2);
            check("nops_early", 32'(timer_int_o), 32'h0);
            idle(1);
            check("nops_fire", 32'(timer_int_o), 32'h1);
            rd_chk("nops_ctrl", 32'h00, 32'h0006);
        end

        idle(2);
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
